// File: rtl/mac_cluster_ctrl_if.sv
// Beat handshake and MAC-cluster control bus for mac_cluster_ctrl.
// The slave modport belongs to the controller. The master modport belongs to the
// environment, which drives the beat and observes the cluster controls.
interface mac_cluster_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  mac_en;
  logic                  mac_done;
  logic                  mac_add_bias;
  logic                  mac_relu;
  logic                  mac_cache_clear_n;
  logic                  mac_cache_wr_en;
  logic [ADDR_WIDTH-1:0] mac_cache_rd_addr;
  logic [ADDR_WIDTH-1:0] mac_cache_wr_addr;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid,
    input  in_ready, mac_en, mac_done, mac_add_bias, mac_relu, mac_cache_clear_n,
           mac_cache_wr_en, mac_cache_rd_addr, mac_cache_wr_addr, out_valid, out_addr
  );

  modport slave (
    input  in_valid,
    output in_ready, mac_en, mac_done, mac_add_bias, mac_relu, mac_cache_clear_n,
           mac_cache_wr_en, mac_cache_rd_addr, mac_cache_wr_addr, out_valid, out_addr
  );
endinterface

// File: rtl/mac_cluster_ctrl.sv
// MAC cluster sequencer. It walks output positions (inner loop) across input-channel
// chunks (outer loop), one beat per issue. Partial sums are stored in the cluster's
// psum cache, and a final-result strobe is raised for writeback.
// Optional feature: define MAC_CTRL_STALL_CNT_EN to count hazard bubbles on o_stall_cnt.
module mac_cluster_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int CHUNK_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [CHUNK_WIDTH-1:0] i_cfg_chunks,
  input  logic [ADDR_WIDTH:0]    i_cfg_outputs,
  input  logic                   i_cfg_bias,
  input  logic                   i_cfg_relu,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_WIDTH-1:0]   o_stall_cnt,
  mac_cluster_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                 r_state;
  state_t                 w_next;
  logic [CHUNK_WIDTH-1:0] r_chunks;
  logic [ADDR_WIDTH:0]    r_outputs;
  logic                   r_bias;
  logic                   r_relu;
  logic [CHUNK_WIDTH-1:0] r_k;
  logic [ADDR_WIDTH-1:0]  r_p;
  logic                   r_wr_en;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic                   r_out_valid;
  logic [ADDR_WIDTH-1:0]  r_out_addr;

  logic w_accept;
  logic w_run;
  logic w_hazard;
  logic w_ready;
  logic w_issue;
  logic w_last_k;
  logic w_last_p;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_cfg_chunks != '0) &&
                    (i_cfg_outputs != '0) && (i_cfg_outputs <= MAX_P);
  assign w_run    = (r_state == S_RUN);
  // The write-back of the previous issue targets the position about to be read.
  // This happens only when P=1. Hold off one cycle so the read sees the updated psum.
  assign w_hazard = w_run && r_wr_en && (r_wr_addr == r_p);
  assign w_ready  = w_run && !w_hazard;
  assign w_issue  = bus.in_valid && w_ready;
  assign w_last_k = (r_k == r_chunks - CHUNK_WIDTH'(1));
  assign w_last_p = ({1'b0, r_p} == r_outputs - (ADDR_WIDTH + 1)'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (w_issue && w_last_k && w_last_p) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job configuration is captured once, when the start request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunks  <= '0;
      r_outputs <= '0;
      r_bias    <= 1'b0;
      r_relu    <= 1'b0;
    end else if (w_accept) begin
      r_chunks  <= i_cfg_chunks;
      r_outputs <= i_cfg_outputs;
      r_bias    <= i_cfg_bias;
      r_relu    <= i_cfg_relu;
    end
  end

  // Loop counters: position p inner, chunk k outer, both advancing only on issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= '0;
      r_p <= '0;
    end else if (w_accept) begin
      r_k <= '0;
      r_p <= '0;
    end else if (w_issue) begin
      if (w_last_p) begin
        r_p <= '0;
        r_k <= r_k + CHUNK_WIDTH'(1);
      end else begin
        r_p <= r_p + ADDR_WIDTH'(1);
      end
    end
  end

  // Cluster result is ready one cycle after issue: write the partial sum back, or flag the final sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_wr_en     <= w_issue && !w_last_k;
      r_out_valid <= w_issue && w_last_k;
      if (w_issue && !w_last_k) r_wr_addr  <= r_p;
      if (w_issue && w_last_k)  r_out_addr <= r_p;
    end
  end

`ifdef MAC_CTRL_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Saturating count of bubbles that actually held back a waiting beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  r_stall_cnt <= '0;
    else if (w_accept)                                        r_stall_cnt <= '0;
    else if (w_hazard && bus.in_valid && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_busy                = (r_state != S_IDLE);
  assign o_done                = (r_state == S_DRAIN);
  assign bus.in_ready          = w_ready;
  assign bus.mac_en            = w_issue;
  assign bus.mac_done          = w_issue && w_last_k;
  assign bus.mac_add_bias      = w_issue && r_bias && (r_k == '0);
  assign bus.mac_relu          = w_issue && r_relu && w_last_k;
  assign bus.mac_cache_clear_n = (r_state != S_CLEAR);
  assign bus.mac_cache_rd_addr = w_run ? r_p : '0;
  assign bus.mac_cache_wr_en   = r_wr_en;
  assign bus.mac_cache_wr_addr = r_wr_addr;
  assign bus.out_valid         = r_out_valid;
  assign bus.out_addr          = r_out_addr;

endmodule

// File: tb/tb_mac_cluster_ctrl.sv
// Scoreboard bench for mac_cluster_ctrl. For each job, the driver pushes the expected
// issue, write-back, result and done events into queues. A negedge monitor pops an entry
// and compares it each time the DUT presents one of those events.
module tb_mac_cluster_ctrl;

`ifdef MAC_CTRL_STALL_CNT_EN
  localparam int STALL_EXP = 2;
`else
  localparam int STALL_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cfg_chunks;
  logic [5:0]  cfg_outputs;
  logic        cfg_bias;
  logic        cfg_relu;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  mac_cluster_ctrl_if #(.ADDR_WIDTH(5)) u_if ();

  mac_cluster_ctrl #(.ADDR_WIDTH(5), .CHUNK_WIDTH(6), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_cfg_chunks  (cfg_chunks),
    .i_cfg_outputs (cfg_outputs),
    .i_cfg_bias    (cfg_bias),
    .i_cfg_relu    (cfg_relu),
    .o_busy        (busy),
    .o_done        (done),
    .o_stall_cnt   (stall_cnt),
    .bus           (u_if.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // issue entries: {add_bias, mac_done, relu, rd_addr}
  logic [7:0] q_iss[$];
  logic [4:0] q_wr[$];
  logic [4:0] q_out[$];
  logic [4:0] q_done[$];

  int          clears = 0;
  int          issues = 0;
  logic [31:0] pat    = '0;
  logic        prev_nf = 1'b0;
  logic        prev_f  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got a DUT event, required none (queue empty)", nm);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_nf = 1'b0;
      prev_f  = 1'b0;
    end else begin
      chk("wr_timing", u_if.mac_cache_wr_en, prev_nf);
      chk("ov_timing", u_if.out_valid, prev_f);
      if (u_if.mac_en) begin
        issues++;
        chk("en_handshake", {u_if.in_valid, u_if.in_ready}, 2'b11);
        if (q_iss.size() == 0) unexpected("issue");
        else chk("issue", {u_if.mac_add_bias, u_if.mac_done, u_if.mac_relu, u_if.mac_cache_rd_addr},
                 q_iss.pop_front());
      end
      if (u_if.mac_cache_wr_en) begin
        if (q_wr.size() == 0) unexpected("wr_addr");
        else chk("wr_addr", u_if.mac_cache_wr_addr, q_wr.pop_front());
      end
      if (u_if.out_valid) begin
        if (q_out.size() == 0) unexpected("out_addr");
        else chk("out_addr", u_if.out_addr, q_out.pop_front());
      end
      if (done) begin
        chk("done_with_ov", u_if.out_valid, 1'b1);
        if (q_done.size() == 0) unexpected("done");
        else chk("done_addr", u_if.out_addr, q_done.pop_front());
      end
      if (!u_if.mac_cache_clear_n) begin
        clears++;
        chk("clear_state", {busy, u_if.in_ready}, 2'b10);
      end
      if (busy && u_if.mac_cache_clear_n && !done) pat = {pat[30:0], u_if.in_ready};
      prev_nf = u_if.mac_en & ~u_if.mac_done;
      prev_f  = u_if.mac_en &  u_if.mac_done;
    end
  end

  task automatic push_exp(input int K, input int P, input bit bias, input bit relu);
    for (int k = 0; k < K; k++) begin
      for (int p = 0; p < P; p++) begin
        q_iss.push_back({(bias && k == 0), (k == K - 1), (relu && k == K - 1), 5'(p)});
        if (k < K - 1) q_wr.push_back(5'(p));
        else           q_out.push_back(5'(p));
      end
    end
    q_done.push_back(5'(P - 1));
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_ctl"}, {busy, done, u_if.in_ready, u_if.mac_en, u_if.mac_done, u_if.mac_add_bias,
                       u_if.mac_relu, u_if.mac_cache_wr_en, u_if.out_valid, u_if.mac_cache_clear_n},
        10'b0000000001);
    chk({nm, "_addr"}, {u_if.mac_cache_rd_addr, u_if.mac_cache_wr_addr, u_if.out_addr}, 15'd0);
    chk({nm, "_stall"}, stall_cnt, 16'd0);
  endtask

  // Runs one job with in_valid held high. A two-cycle in_valid gap can be inserted
  // after gap_at issues. Optionally, a start with different cfg is pulsed mid-job.
  task automatic run_job(input string nm, input int K, input int P, input bit bias, input bit relu,
                         input int gap_at, input bit restart, input int exp_cyc,
                         input logic [31:0] exp_pat, input int pat_n, input int exp_stall);
    int cyc, gap_left, c0, i0;
    bit gap_done;
    push_exp(K, P, bias, relu);
    c0 = clears;
    @(posedge clk); #1;
    cfg_chunks = 6'(K); cfg_outputs = 6'(P); cfg_bias = bias; cfg_relu = relu;
    start = 1'b1; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i0 = issues; cyc = 1; gap_left = 0; gap_done = 1'b0;
    while (busy && cyc < 400) begin
      if (restart && cyc == 3) begin
        start = 1'b1; cfg_chunks = 6'd5; cfg_outputs = 6'd7; cfg_bias = ~bias; cfg_relu = ~relu;
      end else begin
        start = 1'b0;
      end
      if (gap_at >= 0 && !gap_done && (issues - i0) == gap_at) begin
        u_if.in_valid = 1'b0; gap_left = 2; gap_done = 1'b1;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) u_if.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    u_if.in_valid = 1'b0;
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_iss_left"}, q_iss.size(), 0);
    chk({nm, "_wr_left"}, q_wr.size() + q_out.size() + q_done.size(), 0);
    chk({nm, "_clears"}, clears - c0, 1);
    chk({nm, "_stall"}, stall_cnt, exp_stall);
    if (pat_n > 0) chk({nm, "_ready_pat"}, pat & ((32'd1 << pat_n) - 1), exp_pat);
  endtask

  task automatic try_invalid(input string nm, input int K, input int P);
    @(posedge clk); #1;
    cfg_chunks = 6'(K); cfg_outputs = 6'(P); cfg_bias = 1'b1; cfg_relu = 1'b1;
    start = 1'b1; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_busy"}, {busy, u_if.mac_cache_clear_n}, 2'b01);
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_chunks = '0; cfg_outputs = '0;
    cfg_bias = 1'b0; cfg_relu = 1'b0; u_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_init");
    rst = 1'b0;

    // K=1,P=4 with bias+relu, plus a start/cfg change while busy: 4+3 cycles
    run_job("k1p4", 1, 4, 1'b1, 1'b1, -1, 1'b1, 7, 32'h0, 0, 0);
    // K=3,P=2 bias only: 6+3 = 9 cycles
    run_job("k3p2", 3, 2, 1'b1, 1'b0, -1, 1'b0, 9, 32'h0, 0, 0);
    // K=3,P=1 hazard bubbles: ready 1,0,1,0,1, 8 cycles
    run_job("k3p1", 3, 1, 1'b0, 1'b1, -1, 1'b0, 8, 32'b10101, 5, STALL_EXP);
    // K=2,P=3 with two-cycle in_valid gap after two issues: 6+3+2 = 11 cycles
    run_job("k2p3gap", 2, 3, 1'b0, 1'b0, 2, 1'b0, 11, 32'h0, 0, 0);

    try_invalid("inv_p0", 2, 0);
    try_invalid("inv_p33", 2, 33);
    try_invalid("inv_k0", 0, 4);

    // Reset asserted mid-RUN
    push_exp(2, 4, 1'b1, 1'b1);
    @(posedge clk); #1;
    cfg_chunks = 6'd2; cfg_outputs = 6'd4; cfg_bias = 1'b1; cfg_relu = 1'b1;
    start = 1'b1; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    q_iss.delete(); q_wr.delete(); q_out.delete(); q_done.delete();
    u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean jobs after reset, including the largest position count
    run_job("post_rst", 1, 2, 1'b0, 1'b1, -1, 1'b0, 5, 32'h0, 0, 0);
    run_job("k2p32", 2, 32, 1'b1, 1'b1, -1, 1'b0, 67, 32'h0, 0, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mac_cluster_ctrl.md
# mac_cluster_ctrl

Sequencer for one MAC cluster: accepts a job (input-channel chunk count, output-position count, bias/ReLU flags), consumes one data/weight beat per issue cycle via a valid/ready handshake, and drives the cluster's enable, done, bias, ReLU, psum-cache clear, read and write controls. Partial sums accumulate across chunks in the cluster's 32-entry local cache. A final-result strobe with the output position is produced for the writeback stage. Sits between the layer scheduler and the MAC cluster datapath.

## Interface
- ADDR_WIDTH, 5, psum cache address width (32 positions)
- CHUNK_WIDTH, 6, width of chunk count (1..63)
- CNT_WIDTH, 16, stall counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- cfg_chunks  in  CHUNK_WIDTH  chunks per job K, valid 1..63
- cfg_outputs  in  ADDR_WIDTH+1  output positions P, valid 1..32
- cfg_bias  in  1  add bias on first chunk
- cfg_relu  in  1  apply ReLU on final chunk
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- in_valid  in  1  upstream data/weight beat valid
- in_ready  out  1  controller accepts beat
- mac_en  out  1  cluster in_en
- mac_done  out  1  cluster in_done
- mac_add_bias  out  1  cluster in_add_bias
- mac_relu  out  1  cluster in_relu
- mac_cache_clear_n  out  1  cluster in_cache_clear (active-low)
- mac_cache_wr_en  out  1  cluster in_cache_wr_en
- mac_cache_rd_addr  out  ADDR_WIDTH  cluster in_cache_rd_addr
- mac_cache_wr_addr  out  ADDR_WIDTH  cluster in_cache_wr_addr
- out_valid  out  1  final sum valid on cluster out_total_sum
- out_addr  out  ADDR_WIDTH  position of that final sum
- stall_cnt  out  CNT_WIDTH  hazard-bubble count (macro-gated)

## Operation
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE: start with 1<=cfg_chunks and 1<=cfg_outputs<=32 latches cfg, resets k=0, p=0, goes CLEAR. Invalid cfg: start ignored, stays IDLE.
- CLEAR: mac_cache_clear_n=0 for exactly one cycle; -> RUN.
- RUN: issue = in_valid & in_ready. Loop order: p inner (0..P-1), k outer (0..K-1). Each issue advances p; p wraps to 0 and k increments at p=P-1.
- Issue-cycle outputs (combinational, low when no issue): mac_en=1; mac_add_bias=cfg_bias&(k==0); mac_done=(k==K-1); mac_relu=cfg_relu&(k==K-1).
- mac_cache_rd_addr=p at all times in RUN; 0 elsewhere.
- Non-final issue (k<K-1): next cycle mac_cache_wr_en=1, mac_cache_wr_addr=p of that issue.
- Final issue (k==K-1): no write; next cycle out_valid=1, out_addr=p of that issue.
- Issue of (K-1,P-1) -> DRAIN. DRAIN: last out_valid, done=1; -> IDLE. busy=1 in CLEAR, RUN, DRAIN.
- Hazard: if mac_cache_wr_en is high this cycle and mac_cache_wr_addr==p, in_ready=0 (one bubble). Only occurs when P=1 and K>1.
- start while busy ignored; cfg changes after latching have no effect.
- rst: state IDLE; busy, done, in_ready, mac_en, mac_done, mac_add_bias, mac_relu, mac_cache_wr_en, out_valid = 0; addresses 0; stall_cnt 0; mac_cache_clear_n=1.

## Timing
- start (IDLE, edge t) -> CLEAR cycle t+1 -> first possible issue cycle t+2.
- Issue at cycle n -> cluster registers sum at edge n+1 -> cache write/out_valid in cycle n+1.
- Full throughput: one issue per cycle when P>=2 and in_valid held; job = K*P+3 cycles start-to-IDLE.
- P=1, K>1: issues every other cycle; last issue never bubbled.
- in_ready=1 in RUN unless hazard; 0 in IDLE, CLEAR, DRAIN.

## Configuration
- MAC_CTRL_STALL_CNT_EN defined: stall_cnt increments (saturating) each RUN cycle with hazard bubble while in_valid=1; cleared on accepted start.
- Not defined: stall_cnt tied to 0, no counter logic.

## Test plan
- K=1,P=4,bias,relu, in_valid held -> 4 consecutive issues with mac_done=mac_relu=mac_add_bias=1, no wr_en, out_valid with out_addr 0,1,2,3, done with addr 3.
- K=3,P=2 -> issues (k,p)=(0,0),(0,1),(1,0),(1,1),(2,0),(2,1); wr_en next cycle with wr_addr 0,1,0,1; bias only first two; out_addr 0,1; 9 cycles start-to-IDLE.
- K=3,P=1, in_valid held -> in_ready 1,0,1,0,1; stall_cnt=2 with macro, 0 without.
- K=2,P=3, in_valid low 2 cycles mid-job -> mac_en and following wr_en low those cycles; sequence resumes at same (k,p).
- rst asserted mid-RUN -> all outputs reset values same cycle; new start then runs cleanly from CLEAR.
- start with cfg_outputs=0 or 33, or cfg_chunks=0 -> busy stays 0; start while busy -> no effect.
